dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder (target) end of the core's data-memory load/store interface: accepts one request at a time from the core-side initiator over a valid/ready handshake.
- Performs RV32I-sized byte/half/word loads and stores into an internal word-organised RAM after a fixed programmable latency.
- Returns a response (load data or store acknowledge, plus error flag) over a second valid/ready handshake.
- Sits between the pipeline's memory stage and the data RAM.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles spent in WAIT between request accept and response; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  input  3  RV32I size/sign code
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts any pending request: no RAM write occurs and no response is issued.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at an edge: capture we/addr/wdata/funct3, load cnt=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0: perform the access, register rsp_rdata and rsp_err, go to RESP.
  - Response therefore appears exactly LATENCY cycles after the accepting edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until handshake.
  - On rsp_ready=1 at an edge: go to IDLE, rsp_valid=0, and clear rsp_rdata and rsp_err to 0.
  - No new request is accepted in the same cycle; req_ready rises the cycle after.
- Maximum throughput is one transaction per LATENCY+2 cycles when rsp_ready is held high.
- Loads, by funct3:
  - 000 lb: sign-extend byte addr[1:0].
  - 001 lh: sign-extend half addr[1].
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - 011, 110, 111: illegal.
- Stores, by funct3:
  - 000 sb: writes lane addr[1:0].
  - 001 sh: writes lanes {addr[1],0} and {addr[1],1}.
  - 010 sw: writes all 4 lanes.
  - Other codes: illegal.
  - Untouched byte lanes keep their previous value.
- Byte ordering is little-endian: lane 0 is bits [7:0].
- Errors (rsp_err=1, rsp_rdata=0, no RAM write):
  - Illegal funct3.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
- The store write commits at the WAIT->RESP edge. A subsequent load to the same address returns the new value.
- Inputs are sampled only at the accept edge. Changes on req_* while not in IDLE are ignored.
- req_valid held high across a transaction is treated as a new request the next time the FSM is in IDLE. The initiator must drop req_valid after its accept.

Test Plan:
- LATENCY=2. In IDLE, sw addr=0x10 wdata=0xDEADBEEF, rsp_ready=1 → rsp_valid=1 exactly 2 cycles after accept edge with rsp_err=0, rsp_rdata=0; then lw 0x10 → rsp_rdata=0xDEADBEEF.
- After the above: sb addr=0x11 wdata=0x00000080 → lw 0x10 returns 0xDEAD80EF; lb 0x11 returns 0xFFFFFF80; lbu 0x11 returns 0x00000080.
- sh addr=0x12 wdata=0x00001234 → lw 0x10 returns 0x123480EF; lhu 0x12 returns 0x00001234.
- Errors:
  - lw addr=0x13 → rsp_err=1, rsp_rdata=0.
  - sh addr=0x11 → rsp_err=1, and a following lw 0x10 still returns 0x123480EF.
  - lw addr=0x400 (DEPTH_WORDS=256) → rsp_err=1.
  - funct3=011 → rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable and req_ready=0 throughout; raise rsp_ready → rsp_valid=0 next cycle, and req_ready=1 in that same cycle.
- Reset mid-WAIT: accept sw addr=0x20 wdata=0x11111111, assert rst one cycle later → rsp_valid never asserts, req_ready=1 after reset, and lw 0x20 returns the pre-existing value (not 0x11111111).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed
// programmable latency, word-organised little-endian RAM, sized RV32I accesses.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | request captured; latency down-counter running
// RESP  | response registered; held until rsp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          in_range;
  logic          legal;
  logic          misaligned;
  logic          err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wr_lanes;
  logic          access_now;
  logic          mem_we;

  assign idx        = addr_q[AW+1:2];
  assign in_range   = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
  assign rd_word    = in_range ? mem[idx] : 32'd0;
  assign rd_half    = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
  assign access_now = (state == WAIT) && (cnt == 4'd0);
  assign err        = !legal || misaligned || !in_range;
  // Reset wins over a commit landing on the same edge, so an aborted store never writes.
  assign mem_we     = access_now && we_q && !err && !rst;

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);

  always_comb begin
    rd_byte = rd_word[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    load_data  = 32'd0;
    be         = 4'b0000;
    wr_lanes   = wdata_q;
    case (f3_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (we_q) begin
      case (f3_q)
        3'b000: begin
          legal    = 1'b1;
          be       = 4'b0001 << addr_q[1:0];
          wr_lanes = {4{wdata_q[7:0]}};
        end
        3'b001: begin
          legal    = 1'b1;
          be       = addr_q[1] ? 4'b1100 : 4'b0011;
          wr_lanes = {2{wdata_q[15:0]}};
        end
        3'b010: begin
          legal    = 1'b1;
          be       = 4'b1111;
        end
        default: legal = 1'b0;
      endcase
    end else begin
      case (f3_q)
        3'b000: begin legal = 1'b1; load_data = {{24{rd_byte[7]}}, rd_byte}; end
        3'b001: begin legal = 1'b1; load_data = {{16{rd_half[15]}}, rd_half}; end
        3'b010: begin legal = 1'b1; load_data = rd_word; end
        3'b100: begin legal = 1'b1; load_data = {24'd0, rd_byte}; end
        3'b101: begin legal = 1'b1; load_data = {16'd0, rd_half}; end
        default: legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      f3_q      <= 3'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_rdata <= (err || we_q) ? 32'd0 : load_data;
            rsp_err   <= err;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
